// File: rtl/spi_responder_if.sv
// spi_responder_if: the SPI pin group shared by the host and the responder.
// The host drives SCLK/CS_L/MOSI. The responder drives MISO and DRDY_L.
interface spi_responder_if;
  logic SCLK_i;
  logic CS_L_i;
  logic MOSI_i;
  logic MISO_o;
  logic DRDY_L_o;

  modport master (output SCLK_i, CS_L_i, MOSI_i, input MISO_o, DRDY_L_o);
  modport slave  (input SCLK_i, CS_L_i, MOSI_i, output MISO_o, DRDY_L_o);
endinterface

// File: rtl/spi_responder.sv
// spi_responder: the device end of an SPI command/readout link (CPOL=0, CPHA=1).
// It receives a CMD_WIDTH-bit command. RDATA_CMD returns the DATA_WIDTH-bit
// holding register on MISO. Any other command is strobed out to fabric on cmd_o.
// SCLK, CS_L and MOSI are asynchronous. Each passes through a SYNC_STAGES flop
// chain and then a registered edge detector.
// Optional macro SPI_RESP_TIMEOUT_EN adds a stall watchdog. The watchdog aborts
// a frame that sits in CMD or RESP for TIMEOUT_CYCLES with no SCLK or CS_L edge.
module spi_responder #(
  parameter int                   CMD_WIDTH      = 8,
  parameter int                   DATA_WIDTH     = 24,
  parameter logic [CMD_WIDTH-1:0] RDATA_CMD      = 'h01,
  parameter int                   SYNC_STAGES    = 2,
  parameter int                   TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock_i,
  input  logic                  reset_L_i,
  spi_responder_if.slave        spi,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
  output logic [CMD_WIDTH-1:0]  cmd_o,
  output logic                  cmd_valid_o,
  output logic                  rdata_done_o,
  output logic                  abort_o,
  output logic                  busy_o
);

  localparam int CNT_MAX_BITS = (DATA_WIDTH > CMD_WIDTH) ? DATA_WIDTH : CMD_WIDTH;
  localparam int CNT_W        = $clog2(CNT_MAX_BITS + 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_FULL = CNT_W'(DATA_WIDTH);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_DECODE, ST_RESP, ST_WAIT_CS} state_t;

  state_t                  r_state, w_state_next;
  logic [SYNC_STAGES-1:0]  r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                    r_sclk_prev, r_cs_prev;
  logic                    r_sclk_rise, r_sclk_fall, r_cs_rise, r_cs_fall;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [CMD_WIDTH-1:0]    r_cmd_shift, r_cmd;
  logic [DATA_WIDTH-1:0]   r_tx_shift, r_hold, r_pend;
  logic                    r_pend_valid, r_drdy_l, r_miso;
  logic                    r_cmd_valid, r_rdata_done, r_abort;
  logic                    w_cmd_valid_next, w_rdata_done_next, w_abort_next;
  logic                    w_cmd_shift, w_tx_shift, w_tx_load;
  logic                    w_in_readout, w_leaving_readout, w_timeout;
  logic                    w_sclk_s, w_cs_s, w_mosi_s;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // Synchronize the asynchronous pins, then register single-cycle edge pulses
  always_ff @(posedge clock_i or negedge reset_L_i) begin
    if (!reset_L_i) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
      r_sclk_rise <= 1'b0;
      r_sclk_fall <= 1'b0;
      r_cs_rise   <= 1'b0;
      r_cs_fall   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.SCLK_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi.CS_L_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.MOSI_i};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
      r_sclk_rise <= w_sclk_s & ~r_sclk_prev;
      r_sclk_fall <= ~w_sclk_s & r_sclk_prev;
      r_cs_rise   <= w_cs_s & ~r_cs_prev;
      r_cs_fall   <= ~w_cs_s & r_cs_prev;
    end
  end

`ifdef SPI_RESP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            w_any_edge;
  assign w_any_edge = r_sclk_rise | r_sclk_fall | r_cs_rise | r_cs_fall;
  assign w_timeout  = (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

  // Stall watchdog: counts idle cycles inside CMD/RESP, restarts on any pin edge
  always_ff @(posedge clock_i or negedge reset_L_i) begin
    if (!reset_L_i) begin
      r_to_cnt <= '0;
    end else if (w_any_edge || !(r_state == ST_CMD || r_state == ST_RESP)) begin
      r_to_cnt <= '0;
    end else if (!w_timeout) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state decode: frame sequencing, abort handling and strobe requests
  always_comb begin
    w_state_next      = r_state;
    w_cmd_valid_next  = 1'b0;
    w_rdata_done_next = 1'b0;
    w_abort_next      = 1'b0;
    w_cmd_shift       = 1'b0;
    w_tx_shift        = 1'b0;
    w_tx_load         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_cs_fall) w_state_next = ST_CMD;
      end
      ST_CMD: begin
        if (r_cs_rise || w_timeout) begin
          w_state_next = ST_IDLE;
          w_abort_next = 1'b1;
        end else if (r_sclk_fall) begin
          w_cmd_shift = 1'b1;
          if (r_bit_cnt == CMD_LAST) w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (r_cs_rise) begin
          w_state_next = ST_IDLE;
          w_abort_next = 1'b1;
        end else if (r_cmd_shift == RDATA_CMD) begin
          w_tx_load    = 1'b1;
          w_state_next = ST_RESP;
        end else begin
          w_cmd_valid_next = 1'b1;
          w_state_next     = ST_WAIT_CS;
        end
      end
      ST_RESP: begin
        if (r_cs_rise || w_timeout) begin
          w_state_next = ST_IDLE;
          w_abort_next = 1'b1;
        end else if (r_sclk_rise && r_bit_cnt < DATA_FULL) begin
          w_tx_shift = 1'b1;
        end else if (r_sclk_fall && r_bit_cnt == DATA_FULL) begin
          w_rdata_done_next = 1'b1;
          w_state_next      = ST_WAIT_CS;
        end
      end
      ST_WAIT_CS: begin
        if (r_cs_rise) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register and registered one-cycle strobes (cmd_o moves with cmd_valid_o)
  always_ff @(posedge clock_i or negedge reset_L_i) begin
    if (!reset_L_i) begin
      r_state      <= ST_IDLE;
      r_cmd        <= '0;
      r_cmd_valid  <= 1'b0;
      r_rdata_done <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cmd_valid  <= w_cmd_valid_next;
      r_rdata_done <= w_rdata_done_next;
      r_abort      <= w_abort_next;
      if (w_cmd_valid_next) r_cmd <= r_cmd_shift;
    end
  end

  // Bit counter, command shifter, TX shifter and MISO driver
  always_ff @(posedge clock_i or negedge reset_L_i) begin
    if (!reset_L_i) begin
      r_bit_cnt   <= '0;
      r_cmd_shift <= '0;
      r_tx_shift  <= '0;
      r_miso      <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || r_state == ST_DECODE) begin
        r_bit_cnt <= '0;
      end else if ((w_cmd_shift || w_tx_shift) && r_bit_cnt != DATA_FULL) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_cmd_shift) r_cmd_shift <= {r_cmd_shift[CMD_WIDTH-2:0], w_mosi_s};
      if (w_tx_load) begin
        r_tx_shift <= r_hold;
      end else if (w_tx_shift) begin
        r_tx_shift <= r_tx_shift << 1;
      end
      if (w_tx_shift) begin
        r_miso <= r_tx_shift[DATA_WIDTH-1];
      end else if (w_state_next != ST_RESP) begin
        r_miso <= 1'b0;
      end
    end
  end

  // A sample arriving mid-readout is parked and promoted when the readout ends
  assign w_in_readout      = (r_state == ST_DECODE) || (r_state == ST_RESP);
  assign w_leaving_readout = w_in_readout &&
                             (w_state_next == ST_IDLE || w_state_next == ST_WAIT_CS);

  // Holding/pending sample registers and the DRDY_L flag
  always_ff @(posedge clock_i or negedge reset_L_i) begin
    if (!reset_L_i) begin
      r_hold       <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_drdy_l     <= 1'b1;
    end else begin
      if (w_tx_load) r_drdy_l <= 1'b1;
      if (sample_valid_i) begin
        if (w_in_readout && !w_leaving_readout) begin
          r_pend       <= sample_i;
          r_pend_valid <= 1'b1;
        end else begin
          r_hold       <= sample_i;
          r_pend_valid <= 1'b0;
          r_drdy_l     <= 1'b0;
        end
      end else if (w_leaving_readout && r_pend_valid) begin
        r_hold       <= r_pend;
        r_pend_valid <= 1'b0;
        r_drdy_l     <= 1'b0;
      end
    end
  end

  assign spi.MISO_o   = r_miso;
  assign spi.DRDY_L_o = r_drdy_l;
  assign cmd_o        = r_cmd;
  assign cmd_valid_o  = r_cmd_valid;
  assign rdata_done_o = r_rdata_done;
  assign abort_o      = r_abort;
  assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: host-side bench for spi_responder with randomized samples
// and commands. Expected values come from a small sample/DRDY model kept here.
module tb_spi_responder;
  localparam int HALF = 6;  // SCLK half period in clock_i cycles

  logic        clock_i = 1'b0;
  logic        reset_L_i = 1'b0;
  logic [23:0] sample_i = '0;
  logic        sample_valid_i = 1'b0;
  logic [7:0]  cmd_o;
  logic        cmd_valid_o, rdata_done_o, abort_o, busy_o;

  spi_responder_if bus ();

  spi_responder #(.TIMEOUT_CYCLES(64)) dut (
    .clock_i        (clock_i),
    .reset_L_i      (reset_L_i),
    .spi            (bus),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .cmd_o          (cmd_o),
    .cmd_valid_o    (cmd_valid_o),
    .rdata_done_o   (rdata_done_o),
    .abort_o        (abort_o),
    .busy_o         (busy_o)
  );

  always #5 clock_i = ~clock_i;

  int total = 0;
  int bad   = 0;

  // Free-running event counters; tests take deltas
  int          n_cv = 0, n_done = 0, n_abort = 0, n_miso_hi = 0;
  logic [7:0]  last_cmd = '0;
  always @(negedge clock_i) begin
    if (cmd_valid_o) begin n_cv++; last_cmd = cmd_o; end
    if (rdata_done_o) n_done++;
    if (abort_o) n_abort++;
    if (bus.MISO_o === 1'b1) n_miso_hi++;
  end

  // Reference model: what the host should read and what DRDY_L should show
  logic [23:0] m_hold = '0;
  logic        m_drdy_l = 1'b1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic host_bit(input logic mosi, output logic miso);
    bus.SCLK_i = 1'b1;
    bus.MOSI_i = mosi;
    repeat (HALF) @(negedge clock_i);
    miso = bus.MISO_o;
    bus.SCLK_i = 1'b0;
    repeat (HALF) @(negedge clock_i);
  endtask

  task automatic pulse_sample(input logic [23:0] v);
    sample_i = v;
    sample_valid_i = 1'b1;
    @(negedge clock_i);
    sample_valid_i = 1'b0;
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input int n_cmd, input int n_resp,
                           input int strobe_at, input logic [23:0] strobe_val,
                           input bit end_frame, output logic [23:0] rx, output logic drdy_mid);
    logic m;
    rx = '0;
    drdy_mid = 1'bx;
    bus.CS_L_i = 1'b0;
    repeat (8) @(negedge clock_i);
    for (int i = 0; i < n_cmd; i++) host_bit(cmd[7-i], m);
    for (int i = 0; i < n_resp; i++) begin
      if (i == strobe_at) pulse_sample(strobe_val);
      host_bit(1'b0, m);
      rx = {rx[22:0], m};
      if (i == 0) drdy_mid = bus.DRDY_L_o;
    end
    if (end_frame) begin
      repeat (4) @(negedge clock_i);
      bus.CS_L_i = 1'b1;
      repeat (10) @(negedge clock_i);
    end
  endtask

  task automatic test_reset;
    logic [23:0] rx;
    logic dm;
    int d0;
    reset_L_i = 1'b0;
    bus.SCLK_i = 1'b0; bus.CS_L_i = 1'b1; bus.MOSI_i = 1'b0;
    repeat (5) @(negedge clock_i);
    total++; if (bus.MISO_o !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b required 0", bus.MISO_o); end
    total++; if (bus.DRDY_L_o !== 1'b1) begin bad++; $display("FAIL reset_drdy: got %b required 1", bus.DRDY_L_o); end
    total++; if (cmd_o !== 8'h00) begin bad++; $display("FAIL reset_cmd: got %h required 00", cmd_o); end
    total++; if ({cmd_valid_o, rdata_done_o, abort_o, busy_o} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes: got %b required 0000", {cmd_valid_o, rdata_done_o, abort_o, busy_o}); end
    reset_L_i = 1'b1;
    repeat (5) @(negedge clock_i);
    m_hold = '0; m_drdy_l = 1'b1;
    d0 = n_done;
    spi_frame(8'h01, 8, 24, -1, '0, 1'b1, rx, dm);
    $display("reset rdata: rx=%h exp=%h", rx, m_hold);
    total++; if (rx !== m_hold) begin bad++; $display("FAIL reset_rdata: got %h required %h", rx, m_hold); end
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL reset_done_count: got %0d required 1", n_done - d0); end
  endtask

  task automatic test_rdata;
    logic [23:0] rx, s;
    logic dm;
    int d0, c0;
    for (int k = 0; k < 4; k++) begin
      s = (k == 0) ? 24'hA5C3F0 : 24'($urandom);
      pulse_sample(s);
      m_hold = s; m_drdy_l = 1'b0;
      repeat (2) @(negedge clock_i);
      total++; if (bus.DRDY_L_o !== m_drdy_l) begin bad++; $display("FAIL rdata_drdy_low: got %b required %b", bus.DRDY_L_o, m_drdy_l); end
      d0 = n_done; c0 = n_cv;
      spi_frame(8'h01, 8, 24, -1, '0, 1'b1, rx, dm);
      m_drdy_l = 1'b1;
      $display("rdata: rx=%h exp=%h", rx, m_hold);
      total++; if (rx !== m_hold) begin bad++; $display("FAIL rdata_value: got %h required %h", rx, m_hold); end
      total++; if (dm !== 1'b1) begin bad++; $display("FAIL rdata_drdy_decode: got %b required 1", dm); end
      total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL rdata_done_count: got %0d required 1", n_done - d0); end
      total++; if (n_cv - c0 !== 0) begin bad++; $display("FAIL rdata_no_cmd_valid: got %0d required 0", n_cv - c0); end
      total++; if (bus.DRDY_L_o !== m_drdy_l) begin bad++; $display("FAIL rdata_drdy_after: got %b required %b", bus.DRDY_L_o, m_drdy_l); end
    end
  endtask

  task automatic test_cmd;
    logic [23:0] rx;
    logic [7:0] c;
    logic dm;
    int c0, d0, h0;
    for (int k = 0; k < 4; k++) begin
      c = (k == 0) ? 8'h50 : 8'($urandom);
      if (c == 8'h01) c = 8'h02;
      c0 = n_cv; d0 = n_done; h0 = n_miso_hi;
      spi_frame(c, 8, 0, -1, '0, 1'b1, rx, dm);
      $display("cmd: sent=%h cmd_o=%h", c, last_cmd);
      total++; if (n_cv - c0 !== 1) begin bad++; $display("FAIL cmd_valid_count: got %0d required 1", n_cv - c0); end
      total++; if (last_cmd !== c) begin bad++; $display("FAIL cmd_value: got %h required %h", last_cmd, c); end
      total++; if (n_done - d0 !== 0) begin bad++; $display("FAIL cmd_no_done: got %0d required 0", n_done - d0); end
      total++; if (n_miso_hi - h0 !== 0) begin bad++; $display("FAIL cmd_miso_quiet: got %0d high cycles required 0", n_miso_hi - h0); end
    end
  endtask

  task automatic test_sample_during;
    logic [23:0] rx;
    logic dm;
    pulse_sample(24'h111111);
    m_hold = 24'h111111; m_drdy_l = 1'b0;
    repeat (2) @(negedge clock_i);
    spi_frame(8'h01, 8, 24, 5, 24'h222222, 1'b1, rx, dm);
    $display("during: rx=%h exp=%h", rx, m_hold);
    total++; if (rx !== m_hold) begin bad++; $display("FAIL during_first_value: got %h required %h", rx, m_hold); end
    m_hold = 24'h222222; m_drdy_l = 1'b0;
    total++; if (bus.DRDY_L_o !== m_drdy_l) begin bad++; $display("FAIL during_drdy_after_cs: got %b required %b", bus.DRDY_L_o, m_drdy_l); end
    spi_frame(8'h01, 8, 24, -1, '0, 1'b1, rx, dm);
    m_drdy_l = 1'b1;
    $display("during second: rx=%h exp=%h", rx, m_hold);
    total++; if (rx !== m_hold) begin bad++; $display("FAIL during_second_value: got %h required %h", rx, m_hold); end
  endtask

  task automatic test_back_to_back;
    logic [23:0] rx, s1, s2;
    logic dm;
    s1 = 24'($urandom); s2 = 24'($urandom);
    sample_i = s1; sample_valid_i = 1'b1;
    @(negedge clock_i);
    sample_i = s2;
    @(negedge clock_i);
    sample_valid_i = 1'b0;
    m_hold = s2; m_drdy_l = 1'b0;
    repeat (2) @(negedge clock_i);
    total++; if (bus.DRDY_L_o !== m_drdy_l) begin bad++; $display("FAIL b2b_drdy: got %b required %b", bus.DRDY_L_o, m_drdy_l); end
    spi_frame(8'h01, 8, 24, -1, '0, 1'b1, rx, dm);
    m_drdy_l = 1'b1;
    $display("back_to_back: rx=%h exp=%h", rx, m_hold);
    total++; if (rx !== m_hold) begin bad++; $display("FAIL b2b_value: got %h required %h", rx, m_hold); end
  endtask

  task automatic test_abort;
    logic [23:0] rx, s;
    logic dm;
    int a0, c0, d0, nb;
    for (int k = 0; k < 3; k++) begin
      nb = (k == 0) ? 5 : $urandom_range(1, 7);
      a0 = n_abort; c0 = n_cv;
      spi_frame(8'($urandom), nb, 0, -1, '0, 1'b1, rx, dm);
      $display("abort cmd: bits=%0d aborts=%0d", nb, n_abort - a0);
      total++; if (n_abort - a0 !== 1) begin bad++; $display("FAIL abort_cmd_count: got %0d required 1", n_abort - a0); end
      total++; if (n_cv - c0 !== 0) begin bad++; $display("FAIL abort_no_cmd_valid: got %0d required 0", n_cv - c0); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b required 0", busy_o); end
    end
    // RDATA cut off mid-response: no done strobe, DRDY stays released
    s = 24'($urandom);
    pulse_sample(s);
    m_hold = s; m_drdy_l = 1'b0;
    a0 = n_abort; d0 = n_done;
    spi_frame(8'h01, 8, 7, -1, '0, 1'b1, rx, dm);
    m_drdy_l = 1'b1;
    total++; if (n_abort - a0 !== 1) begin bad++; $display("FAIL abort_resp_count: got %0d required 1", n_abort - a0); end
    total++; if (n_done - d0 !== 0) begin bad++; $display("FAIL abort_resp_no_done: got %0d required 0", n_done - d0); end
    total++; if (bus.DRDY_L_o !== m_drdy_l) begin bad++; $display("FAIL abort_resp_drdy: got %b required %b", bus.DRDY_L_o, m_drdy_l); end
    spi_frame(8'h01, 8, 24, -1, '0, 1'b1, rx, dm);
    $display("after abort: rx=%h exp=%h", rx, m_hold);
    total++; if (rx !== m_hold) begin bad++; $display("FAIL abort_followup_value: got %h required %h", rx, m_hold); end
  endtask

  task automatic test_reset_mid_frame;
    logic [23:0] rx;
    logic dm;
    int a0;
    pulse_sample(24'hFFFFFF);
    m_hold = 24'hFFFFFF;
    spi_frame(8'h01, 8, 10, -1, '0, 1'b0, rx, dm);
    bus.SCLK_i = 1'b1;
    repeat (HALF) @(negedge clock_i);
    total++; if (bus.MISO_o !== 1'b1) begin bad++; $display("FAIL midrst_pre_miso: got %b required 1", bus.MISO_o); end
    a0 = n_abort;
    reset_L_i = 1'b0;
    #1;
    total++; if (bus.MISO_o !== 1'b0) begin bad++; $display("FAIL midrst_miso: got %b required 0", bus.MISO_o); end
    total++; if (bus.DRDY_L_o !== 1'b1) begin bad++; $display("FAIL midrst_drdy: got %b required 1", bus.DRDY_L_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b required 0", busy_o); end
    bus.SCLK_i = 1'b0; bus.CS_L_i = 1'b1;
    repeat (5) @(negedge clock_i);
    reset_L_i = 1'b1;
    repeat (5) @(negedge clock_i);
    total++; if (n_abort - a0 !== 0) begin bad++; $display("FAIL midrst_no_abort: got %0d required 0", n_abort - a0); end
    m_hold = '0; m_drdy_l = 1'b1;
    spi_frame(8'h01, 8, 24, -1, '0, 1'b1, rx, dm);
    $display("after midrst: rx=%h exp=%h", rx, m_hold);
    total++; if (rx !== m_hold) begin bad++; $display("FAIL midrst_rdata: got %h required %h", rx, m_hold); end
  endtask

  task automatic test_timeout;
    logic [23:0] rx;
    logic dm;
    int a0, cyc;
    pulse_sample(24'($urandom));
    a0 = n_abort;
    spi_frame(8'h01, 8, 3, -1, '0, 1'b0, rx, dm);
    m_drdy_l = 1'b1;
    cyc = 0;
    while (n_abort == a0 && cyc < 300) begin
      @(negedge clock_i);
      cyc++;
    end
`ifdef SPI_RESP_TIMEOUT_EN
    $display("timeout: abort after %0d cycles", cyc);
    total++; if (n_abort - a0 !== 1) begin bad++; $display("FAIL timeout_abort: got %0d required 1", n_abort - a0); end
    total++; if (cyc < 50 || cyc > 80) begin bad++; $display("FAIL timeout_latency: got %0d required 50..80", cyc); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b required 0", busy_o); end
    bus.CS_L_i = 1'b1;
    repeat (10) @(negedge clock_i);
    total++; if (n_abort - a0 !== 1) begin bad++; $display("FAIL timeout_cs_end: got %0d required 1", n_abort - a0); end
`else
    $display("no timeout: busy=%b after %0d cycles", busy_o, cyc);
    total++; if (n_abort - a0 !== 0) begin bad++; $display("FAIL stall_no_abort: got %0d required 0", n_abort - a0); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL stall_busy: got %b required 1", busy_o); end
    bus.CS_L_i = 1'b1;
    repeat (10) @(negedge clock_i);
    total++; if (n_abort - a0 !== 1) begin bad++; $display("FAIL stall_cs_abort: got %0d required 1", n_abort - a0); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL stall_busy_end: got %b required 0", busy_o); end
`endif
    total++; if (bus.DRDY_L_o !== m_drdy_l) begin bad++; $display("FAIL stall_drdy: got %b required %b", bus.DRDY_L_o, m_drdy_l); end
  endtask

  initial begin
    test_reset();
    test_rdata();
    test_cmd();
    test_sample_during();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
